// File: rtl/counter_pkg.sv
// counter_pkg: shared mode/direction constants and sizing helper for the up/down counter
package counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: issues step_req once every PRESCALE enabled cycles
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic clear,
    input  logic en,
    input  logic restart,
    output logic step_req
);
    localparam int PW = clog2(PRESCALE) > 0 ? clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] cnt;
    assign step_req = en && cnt == LAST;
    always_ff @(posedge clock or posedge clear)
        if (clear) cnt <= '0;
        else if (restart || step_req) cnt <= '0;
        else if (en) cnt <= cnt + PW'(1);
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo up/down counter with wrap/saturate, load, prescaler and sticky flags
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 255,
    parameter int PRESCALE  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             flag_clr,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);
    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
    if (MAX_COUNT < 1 || longint'(MAX_COUNT) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
        $error("MAX_COUNT out of range");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_pre
        $error("PRESCALE out of range");
    end
    logic step_req, step, at_top, at_bot, bnd;
    logic [WIDTH-1:0] nxt;
    counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clock(clock), .clear(clear), .en(en), .restart(load), .step_req(step_req)
    );
    always_comb begin
        step   = step_req & ~load;
        at_top = count == MAXV;
        at_bot = count == '0;
        bnd    = step & (up == DIR_UP ? at_top : at_bot);
        nxt    = load ? (load_value > MAXV ? MAXV : load_value)
               : !step ? count
               : up == DIR_UP ? (at_top ? (sat_mode == MODE_SAT ? count : '0) : count + WIDTH'(1))
               : (at_bot ? (sat_mode == MODE_SAT ? count : MAXV) : count - WIDTH'(1));
    end
    always_ff @(posedge clock or posedge clear)
        if (clear) begin
            count <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= nxt;
            tick  <= step;
            tc    <= bnd;
            ovf   <= (bnd & up) | (ovf & ~flag_clr);
            unf   <= (bnd & ~up) | (unf & ~flag_clr);
        end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench for two counter configs (PRESCALE 1 and 3)
module tb_mod_updown_counter;
    logic clock = 1'b0, clear = 1'b1, en = 1'b0, up = 1'b1, sat_mode = 1'b0;
    logic load = 1'b0, flag_clr = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic [3:0] c0, c1;
    logic t0, tc0, o0, u0, t1, tc1, o1, u1;
    int total = 0, bad = 0;

    typedef struct packed {
        logic [3:0] c;
        logic t, tc, o, u;
    } exp_t;
    exp_t q[$];
    int mc[2], mp[2];
    logic mt[2], mtc[2], mo[2], mu[2];
    int pv[2] = '{1, 3};

    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1)) dut0 (
        .clock(clock), .clear(clear), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
        .load_value(load_value), .flag_clr(flag_clr), .count(c0), .tick(t0), .tc(tc0), .ovf(o0), .unf(u0)
    );
    mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) dut1 (
        .clock(clock), .clear(clear), .en(en), .up(up), .sat_mode(sat_mode), .load(load),
        .load_value(load_value), .flag_clr(flag_clr), .count(c1), .tick(t1), .tc(tc1), .ovf(o1), .unf(u1)
    );

    always #5 clock = ~clock;

    task automatic model_reset;
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; mp[i] = 0; mt[i] = 0; mtc[i] = 0; mo[i] = 0; mu[i] = 0;
        end
    endtask

    task automatic cyc;
        logic sr, bn;
        exp_t e, got;
        for (int i = 0; i < 2; i++) begin
            sr = en && (mp[i] == pv[i] - 1);
            bn = 1'b0;
            if (load) begin
                mc[i] = load_value > 9 ? 9 : int'(load_value);
                mp[i] = 0; mt[i] = 0; mtc[i] = 0;
            end else begin
                if (en) mp[i] = sr ? 0 : mp[i] + 1;
                bn = sr && (up ? mc[i] == 9 : mc[i] == 0);
                mt[i] = sr; mtc[i] = bn;
                if (sr) mc[i] = bn ? (sat_mode ? mc[i] : (up ? 0 : 9)) : (up ? mc[i] + 1 : mc[i] - 1);
            end
            mo[i] = (bn && up) || (mo[i] && !flag_clr);
            mu[i] = (bn && !up) || (mu[i] && !flag_clr);
            e.c = 4'(mc[i]); e.t = mt[i]; e.tc = mtc[i]; e.o = mo[i]; e.u = mu[i];
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = q.pop_front();
            got = (i == 0) ? {c0, t0, tc0, o0, u0} : {c1, t1, tc1, o1, u1};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scoreboard inst%0d t=%0t: got c=%0d tick=%b tc=%b ovf=%b unf=%b, need c=%0d tick=%b tc=%b ovf=%b unf=%b",
                         i, $time, got.c, got.t, got.tc, got.o, got.u, e.c, e.t, e.tc, e.o, e.u);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({c0, t0, tc0, o0, u0, c1, t1, tc1, o1, u1} !== '0) begin
            bad++;
            $display("FAIL reset: got c0=%0d c1=%0d flags0=%b%b%b%b, need all 0", c0, c1, t0, tc0, o0, u0);
        end
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_up_wrap;
        int tcs;
        tcs = 0;
        en = 1'b1; up = 1'b1; sat_mode = 1'b0;
        repeat (11) begin
            cyc();
            tcs += int'(tc0);
        end
        total++;
        if (c0 !== 4'd1 || tcs != 1 || o0 !== 1'b1 || u0 !== 1'b0) begin
            bad++;
            $display("FAIL up_wrap: got c=%0d tcs=%0d ovf=%b unf=%b, need c=1 tcs=1 ovf=1 unf=0", c0, tcs, o0, u0);
        end
    endtask

    task automatic test_down_flags;
        load_value = 4'd0; load = 1'b1;
        cyc();
        load = 1'b0; up = 1'b0;
        cyc();
        total++;
        if (c0 !== 4'd9 || tc0 !== 1'b1 || u0 !== 1'b1) begin
            bad++;
            $display("FAIL down_wrap: got c=%0d tc=%b unf=%b, need c=9 tc=1 unf=1", c0, tc0, u0);
        end
        cyc();
        cyc();
        total++;
        if (c0 !== 4'd7 || tc0 !== 1'b0) begin
            bad++;
            $display("FAIL down_count: got c=%0d tc=%b, need c=7 tc=0", c0, tc0);
        end
        flag_clr = 1'b1;
        cyc();
        flag_clr = 1'b0;
        total++;
        if (o0 !== 1'b0 || u0 !== 1'b0) begin
            bad++;
            $display("FAIL flag_clr: got ovf=%b unf=%b, need 0 0", o0, u0);
        end
        load = 1'b1;
        cyc();
        load = 1'b0; flag_clr = 1'b1;
        cyc();
        flag_clr = 1'b0;
        total++;
        if (u0 !== 1'b1 || tc0 !== 1'b1 || o0 !== 1'b0) begin
            bad++;
            $display("FAIL set_beats_clr: got unf=%b tc=%b ovf=%b, need 1 1 0", u0, tc0, o0);
        end
    endtask

    task automatic test_sat;
        logic [3:0] ec[4] = '{4'd8, 4'd9, 4'd9, 4'd9};
        logic etc[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        sat_mode = 1'b1; up = 1'b1; load_value = 4'd7; load = 1'b1;
        cyc();
        load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++;
            if (c0 !== ec[k] || tc0 !== etc[k]) begin
                bad++;
                $display("FAIL sat_up step%0d: got c=%0d tc=%b, need c=%0d tc=%b", k, c0, tc0, ec[k], etc[k]);
            end
        end
        load_value = 4'd0; load = 1'b1;
        cyc();
        load = 1'b0; up = 1'b0;
        cyc();
        cyc();
        total++;
        if (c0 !== 4'd0 || u0 !== 1'b1 || tc0 !== 1'b1) begin
            bad++;
            $display("FAIL sat_down: got c=%0d unf=%b tc=%b, need c=0 unf=1 tc=1", c0, u0, tc0);
        end
    endtask

    task automatic test_load;
        sat_mode = 1'b0; up = 1'b1; en = 1'b1;
        load_value = 4'd15; load = 1'b1;
        cyc();
        total++;
        if (c0 !== 4'd9 || t0 !== 1'b0 || tc0 !== 1'b0) begin
            bad++;
            $display("FAIL load_clamp: got c=%0d tick=%b tc=%b, need c=9 tick=0 tc=0", c0, t0, tc0);
        end
        load_value = 4'd3;
        cyc();
        load = 1'b0;
        total++;
        if (c0 !== 4'd3 || t0 !== 1'b0 || tc0 !== 1'b0) begin
            bad++;
            $display("FAIL load_over_step: got c=%0d tick=%b tc=%b, need c=3 tick=0 tc=0", c0, t0, tc0);
        end
    endtask

    task automatic test_prescale;
        en = 1'b1; up = 1'b1; sat_mode = 1'b0; load_value = 4'd0; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        en = 1'b0;
        cyc();
        cyc();
        total++;
        if (t1 !== 1'b0 || c1 !== 4'd0) begin
            bad++;
            $display("FAIL pre_hold: got c=%0d tick=%b, need c=0 tick=0", c1, t1);
        end
        en = 1'b1;
        cyc();
        total++;
        if (t1 !== 1'b1 || c1 !== 4'd1) begin
            bad++;
            $display("FAIL pre_step: got c=%0d tick=%b, need c=1 tick=1", c1, t1);
        end
        cyc();
        load_value = 4'd5; load = 1'b1;
        cyc();
        load = 1'b0;
        cyc();
        cyc();
        total++;
        if (t1 !== 1'b0 || c1 !== 4'd5) begin
            bad++;
            $display("FAIL pre_restart_early: got c=%0d tick=%b, need c=5 tick=0", c1, t1);
        end
        cyc();
        total++;
        if (t1 !== 1'b1 || c1 !== 4'd6) begin
            bad++;
            $display("FAIL pre_restart: got c=%0d tick=%b, need c=6 tick=1", c1, t1);
        end
    endtask

    task automatic test_async_clear;
        en = 1'b0; load_value = 4'd6; load = 1'b1;
        cyc();
        load = 1'b0;
        total++;
        if (c0 !== 4'd6 || o0 !== 1'b1) begin
            bad++;
            $display("FAIL pre_clear_state: got c=%0d ovf=%b, need c=6 ovf=1", c0, o0);
        end
        #2;
        clear = 1'b1;
        #1;
        total++;
        if ({c0, t0, tc0, o0, u0, c1, o1, u1} !== '0) begin
            bad++;
            $display("FAIL async_clear: got c0=%0d ovf=%b unf=%b c1=%0d, need all 0", c0, o0, u0, c1);
        end
        clear = 1'b0;
        model_reset();
        en = 1'b1; up = 1'b1;
        cyc();
        total++;
        if (c0 !== 4'd1 || c1 !== 4'd0) begin
            bad++;
            $display("FAIL resume: got c0=%0d c1=%0d, need 1 0", c0, c1);
        end
        cyc();
        cyc();
        total++;
        if (c1 !== 4'd1 || t1 !== 1'b1) begin
            bad++;
            $display("FAIL resume_pre: got c1=%0d tick=%b, need 1 1", c1, t1);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_up_wrap();
        test_down_flags();
        test_sat();
        test_load();
        test_prescale();
        test_async_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
